// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU definitions used by the instruction fetch queue.
//   XLEN / ILEN  : address and instruction widths
//   INST_NOP     : canonical NOP encoding (addi x0,x0,0)
//   ifq_state_e  : fetch FSM states
//   ifq_entry_t  : one queue entry, {pc, inst}, 96 bits
//   align_pc     : clears the low two bits of a target address
package inst_fetch_queue_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } ifq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~64'd3;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of {pc, inst} entries for the fetch queue.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_flush       : empty the FIFO (pointers and count cleared)
//   i_push        : write i_push_data at the tail
//   i_pop         : drop the head entry
//   o_head        : current head entry (valid when !o_empty)
//   o_full/o_empty/o_count : occupancy status
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  ifq_entry_t    i_push_data,
  input  logic          i_pop,
  output ifq_entry_t    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  ifq_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: credit-based instruction fetch front end.
// Issues sequential fetches to instruction memory, buffers in-order
// responses in fetch_fifo and hands them to decode. A redirect flushes the
// queue and discards responses still in flight (DRAIN state).
// Parameters: DEPTH (entries / max in-flight+buffered), RESET_PC.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   redirect_valid, redirect_pc      : execute-stage redirect
//   imem_req_valid/addr/ready        : fetch request handshake
//   imem_resp_valid/data             : in-order fetch response
//   dec_valid/pc/inst/ready          : decode handshake
//   perf_fetched, perf_dropped       : only with `define IFQ_PERF_EN
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_pc,
  output logic [ILEN-1:0] dec_inst,
  input  logic            dec_ready
`ifdef IFQ_PERF_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_dropped
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = DEPTH[CW:0];

  ifq_state_e      r_state, w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc, r_resp_pc;
  logic [CW-1:0]   r_outstanding, r_drop_cnt, w_drop_nxt, w_count;
  logic [CW-1:0]   w_resp_one, w_fire_one;
  logic            w_full, w_empty, w_issue, w_fire, w_push, w_pop;
  logic            w_resp_dropped, w_dec_valid;
  ifq_entry_t      w_head, w_push_data;

  assign w_resp_one = {{(CW-1){1'b0}}, imem_resp_valid};
  assign w_fire_one = {{(CW-1){1'b0}}, w_fire};

  // Every response is either pushed or dropped; a redirect wins over push.
  // drop_cnt counts pre-redirect responses still owed by memory.
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt;
    w_issue     = 1'b0;
    if (redirect_valid) begin
      w_drop_nxt  = r_outstanding - w_resp_one;
      w_state_nxt = (w_drop_nxt != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: w_issue = ({1'b0, r_outstanding} + {1'b0, w_count}) < LIMIT;
        ST_DRAIN: begin
          if (imem_resp_valid) begin
            w_drop_nxt = r_drop_cnt - 1'b1;
            if (r_drop_cnt == CW'(1)) w_state_nxt = ST_FETCH;
          end
        end
        default: ;
      endcase
    end
    if (rst) w_issue = 1'b0;
  end

  assign w_fire         = w_issue && imem_req_ready;
  assign w_dec_valid    = !w_empty && !rst;
  assign w_pop          = w_dec_valid && dec_ready && !redirect_valid;
  assign w_push         = imem_resp_valid && !redirect_valid && (r_drop_cnt == '0)
                          && (!w_full || w_pop);
  assign w_resp_dropped = imem_resp_valid && (redirect_valid || (r_drop_cnt != '0));
  assign w_push_data    = '{pc: r_resp_pc, inst: imem_resp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (redirect_valid) begin
        r_fetch_pc    <= align_pc(redirect_pc);
        r_resp_pc     <= align_pc(redirect_pc);
        r_outstanding <= r_outstanding - w_resp_one;
      end else begin
        if (w_fire) r_fetch_pc <= r_fetch_pc + 64'd4;
        if (w_push) r_resp_pc  <= r_resp_pc + 64'd4;
        r_outstanding <= r_outstanding + w_fire_one - w_resp_one;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign imem_req_valid = w_issue;
  assign imem_req_addr  = r_fetch_pc;
  assign dec_valid      = w_dec_valid;
  assign dec_pc         = w_dec_valid ? w_head.pc : '0;
  assign dec_inst       = rst ? '0 : (w_dec_valid ? w_head.inst : INST_NOP);

`ifdef IFQ_PERF_EN
  logic [XLEN-1:0] r_perf_fetched, r_perf_dropped;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      r_perf_fetched <= r_perf_fetched + {{(XLEN-1){1'b0}}, w_push};
      r_perf_dropped <= r_perf_dropped
                        + (redirect_valid ? {{(XLEN-CW){1'b0}}, w_count} : '0)
                        + {{(XLEN-1){1'b0}}, w_resp_dropped};
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_dropped = r_perf_dropped;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  localparam int unsigned DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, dec_valid, dec_ready;
  logic [63:0] redirect_pc, imem_req_addr, dec_pc;
  logic [31:0] imem_resp_data, dec_inst;
`ifdef IFQ_PERF_EN
  logic [63:0] perf_fetched, perf_dropped;
`endif

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dec_valid       (dec_valid),
    .dec_pc          (dec_pc),
    .dec_inst        (dec_inst),
    .dec_ready       (dec_ready)
`ifdef IFQ_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_dropped    (perf_dropped)
`endif
  );

  // Reference model: memory holds accepted requests tagged with the
  // redirect epoch they were issued in; stale-epoch responses are discarded.
  typedef struct {
    logic [63:0]     addr;
    int unsigned     epoch;
    longint unsigned due;
  } mreq_t;

  mreq_t           mem_q[$];
  logic [63:0]     dq[$];
  int unsigned     epoch, lat;
  logic [63:0]     m_fetch_pc, m_fetched, m_dropped;
  longint unsigned cyc;
  logic            d_rst, d_redir, d_req_rdy, d_dec_rdy;
  logic [63:0]     d_rpc;
  logic            s_req_v, s_dv;
  logic [63:0]     s_req_addr, s_pc;
  int              n_tests, n_fail;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC3A5_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    int unsigned stale;
    logic        exp_rv, exp_dv, resp, fire, pop;
    mreq_t       it;
    @(negedge clk);
    rst            = d_rst;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    imem_req_ready = d_req_rdy;
    dec_ready      = d_dec_rdy;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? inst_of(mem_q[0].addr) : 32'h0;
    #1;
    stale = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
    exp_rv = !d_rst && !d_redir && (stale == 0) && (mem_q.size() + dq.size() < DEPTH);
    exp_dv = !d_rst && (dq.size() > 0);
    s_req_v = imem_req_valid; s_req_addr = imem_req_addr;
    s_dv = dec_valid; s_pc = dec_pc;
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
    chk("dec_valid", 64'(dec_valid), 64'(exp_dv));
    if (exp_dv) begin
      chk("dec_pc", dec_pc, dq[0]);
      chk("dec_inst", 64'(dec_inst), 64'(inst_of(dq[0])));
    end else if (d_rst) begin
      chk("rst_dec_pc", dec_pc, 64'h0);
      chk("rst_dec_inst", 64'(dec_inst), 64'h0);
    end
`ifdef IFQ_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
`endif
    fire = exp_rv && d_req_rdy;
    pop  = exp_dv && d_dec_rdy;
    if (d_rst) begin
      mem_q.delete(); dq.delete();
      epoch++; m_fetch_pc = RST_PC; m_fetched = '0; m_dropped = '0;
    end else begin
      if (resp) it = mem_q.pop_front();
      if (d_redir) begin
        m_dropped += 64'(dq.size()) + 64'(resp);
        dq.delete();
        epoch++;
        m_fetch_pc = d_rpc & ~64'd3;
      end else begin
        if (pop) void'(dq.pop_front());
        if (resp) begin
          if (it.epoch == epoch) begin dq.push_back(it.addr); m_fetched++; end
          else m_dropped++;
        end
        if (fire) begin
          mem_q.push_back('{addr: m_fetch_pc, epoch: epoch, due: cyc + lat});
          m_fetch_pc += 64'd4;
        end
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_dv(input string tag, input logic [63:0] exp_pc);
    int k = 0;
    step();
    while (!s_dv && k < 40) begin step(); k++; end
    chk({tag, "_dv"}, 64'(s_dv), 64'd1);
    if (s_dv) chk(tag, s_pc, exp_pc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          fires, k;
    logic [63:0] p0, flushed;
    n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; lat = 1;
    m_fetch_pc = RST_PC; m_fetched = '0; m_dropped = '0;
    p0 = '0; flushed = '0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = '0; dec_ready = 1'b1;
    d_rst = 1'b1; d_redir = 1'b0; d_rpc = '0; d_req_rdy = 1'b1; d_dec_rdy = 1'b1;
    run(3);
    d_rst = 1'b0;

    // Reset start: consecutive delivery from RESET_PC at latency 1.
    wait_dv("s1_pc0", RST_PC);
    step(); chk("s1_dv1", 64'(s_dv), 64'd1); chk("s1_pc1", s_pc, RST_PC + 64'd4);
    step(); chk("s1_dv2", 64'(s_dv), 64'd1); chk("s1_pc2", s_pc, RST_PC + 64'd8);

    // Backpressure: exactly DEPTH requests, then in-order drain.
    d_rst = 1'b1; run(2); d_rst = 1'b0;
    d_dec_rdy = 1'b0; fires = 0;
    repeat (10) begin step(); fires += int'(s_req_v && d_req_rdy); end
    chk("s2_reqs", 64'(fires), 64'(DEPTH));
    chk("s2_req_idle", 64'(s_req_v), 64'd0);
    d_dec_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s2_pop_dv", 64'(s_dv), 64'd1);
      chk("s2_pop_pc", s_pc, RST_PC + 64'(4 * i));
    end

    // Redirect with three requests in flight at latency 3.
    d_rst = 1'b1; run(2); d_rst = 1'b0; lat = 3;
    k = 0;
    while (mem_q.size() != 3 && k < 20) begin step(); k++; end
    flushed = 64'(dq.size());
`ifdef IFQ_PERF_EN
    p0 = perf_dropped;
`endif
    d_redir = 1'b1; d_rpc = 64'h2002; step(); d_redir = 1'b0;
    wait_dv("s3_pc", 64'h2000);
`ifdef IFQ_PERF_EN
    chk("s3_perf_drop", perf_dropped - p0, 64'd3 + flushed);
`endif

    // Second redirect while still draining the first.
    k = 0;
    while (mem_q.size() < 2 && k < 20) begin step(); k++; end
    d_redir = 1'b1; d_rpc = 64'h5000; step();
    d_rpc = 64'h3000; step(); d_redir = 1'b0;
    wait_dv("s4_pc", 64'h3000);

    // Reset with buffered entries and requests in flight.
    d_dec_rdy = 1'b0; k = 0;
    while (!(dq.size() >= 2 && mem_q.size() >= 2) && k < 30) begin step(); k++; end
    d_rst = 1'b1; step(); d_rst = 1'b0;
    step();
    chk("s6_dv", 64'(s_dv), 64'd0);
    chk("s6_req_v", 64'(s_req_v), 64'd1);
    chk("s6_req_addr", s_req_addr, RST_PC);

    // Address wrap, then random ready/redirect/reset traffic.
    d_dec_rdy = 1'b1;
    d_redir = 1'b1; d_rpc = 64'hFFFF_FFFF_FFFF_FFF6; step(); d_redir = 1'b0;
    run(20);
    repeat (3000) begin
      d_req_rdy = 1'($urandom % 2);
      d_dec_rdy = (($urandom % 4) != 0);
      d_redir   = (($urandom % 50) == 0);
      d_rpc     = {$urandom, $urandom};
      if (($urandom % 4) == 0) d_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
      d_rst     = (($urandom % 500) == 0);
      if (mem_q.size() == 0) lat = $urandom_range(1, 4);
      step();
    end
    d_rst = 1'b0; d_redir = 1'b0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
